// File: rtl/round_controller.sv
// Round/match sequencer for a two-player fighting game.
// Takes per-player health from the health stage and steps a best-of-N match:
// countdown, fight, KO or timeout, round-end hold, then next round or match over.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   frame_tick      one-clk pulse per video frame; paces every counter
//   start           start/continue request, sampled each clk in IDLE and MATCH_OVER
//   player1_health  P1 health (3 = full; 0 or >=4 means dead)
//   player2_health  P2 health
//   game_active     high only while fighting; gates player input
//   round_rst       resets the health stage and player positions
//   p1_rounds       rounds won by P1 (saturates at 3)
//   p2_rounds       rounds won by P2 (saturates at 3)
//   round_timer     seconds remaining in the current round
//   phase           FSM state code
//   winner          00 none, 01 P1, 10 P2, 11 draw
module round_controller #(
  parameter int unsigned ROUNDS_TO_WIN    = 2,
  parameter int unsigned ROUND_SECONDS    = 60,
  parameter int unsigned FRAMES_PER_SEC   = 60,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned KO_HOLD_FRAMES   = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [2:0] player1_health,
  input  logic [2:0] player2_health,
  output logic       game_active,
  output logic       round_rst,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [6:0] round_timer,
  output logic [2:0] phase,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StReset     = 3'd1,
    StCountdown = 3'd2,
    StFight     = 3'd3,
    StRoundEnd  = 3'd4,
    StMatchOver = 3'd5
  } state_e;

  localparam logic [6:0]  TimerInit     = 7'(ROUND_SECONDS);
  localparam logic [15:0] CountdownLast = 16'(COUNTDOWN_FRAMES - 1);
  localparam logic [15:0] HoldLast      = 16'(KO_HOLD_FRAMES - 1);
  localparam logic [15:0] SecLast       = 16'(FRAMES_PER_SEC - 1);
  localparam logic [1:0]  Target        = 2'(ROUNDS_TO_WIN);

  state_e      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] sec_q, sec_d;
  logic [6:0]  timer_q, timer_d;
  logic [1:0]  p1_q, p1_d, p2_q, p2_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_active_q, round_rst_q;

  logic p1_dead, p2_dead, award_p1, award_p2;

  // A wrapped down-count lands at >=4, so bit 2 set is as dead as zero.
  assign p1_dead = (player1_health == 3'd0) || player1_health[2];
  assign p2_dead = (player2_health == 3'd0) || player2_health[2];

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    sec_d    = sec_q;
    timer_d  = timer_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    award_p1 = 1'b0;
    award_p2 = 1'b0;

    case (state_q)
      StIdle, StMatchOver: begin
        if (start) begin
          state_d  = StReset;
          p1_d     = 2'd0;
          p2_d     = 2'd0;
          winner_d = 2'd0;
        end
      end
      StReset: state_d = StCountdown;
      StCountdown: begin
        if (frame_tick) begin
          if (frame_q == CountdownLast) begin
            state_d = StFight;
            frame_d = 16'd0;
          end else begin
            frame_d = frame_q + 16'd1;
          end
        end
      end
      StFight: begin
        if (p1_dead || p2_dead || (timer_q == 7'd0)) begin
          state_d = StRoundEnd;
          frame_d = 16'd0;
          // KO outranks timeout; on timeout the healthier player (or both) scores.
          if (p1_dead || p2_dead) begin
            award_p1 = p2_dead;
            award_p2 = p1_dead;
          end else begin
            award_p1 = (player1_health >= player2_health);
            award_p2 = (player2_health >= player1_health);
          end
          if (award_p1 && (p1_q != 2'd3)) p1_d = p1_q + 2'd1;
          if (award_p2 && (p2_q != 2'd3)) p2_d = p2_q + 2'd1;
        end else if (frame_tick) begin
          if (sec_q == SecLast) begin
            sec_d = 16'd0;
            if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
          end else begin
            sec_d = sec_q + 16'd1;
          end
        end
      end
      StRoundEnd: begin
        if (frame_tick) begin
          if (frame_q == HoldLast) begin
            frame_d = 16'd0;
            if ((p1_q == Target) || (p2_q == Target)) begin
              state_d  = StMatchOver;
              winner_d = {p2_q == Target, p1_q == Target};
            end else begin
              state_d = StReset;
            end
          end else begin
            frame_d = frame_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Load round values on entry so RESET already shows a full timer.
    if (state_d == StReset) begin
      timer_d = TimerInit;
      frame_d = 16'd0;
      sec_d   = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      frame_q       <= 16'd0;
      sec_q         <= 16'd0;
      timer_q       <= TimerInit;
      p1_q          <= 2'd0;
      p2_q          <= 2'd0;
      winner_q      <= 2'd0;
      game_active_q <= 1'b0;
      round_rst_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      sec_q         <= sec_d;
      timer_q       <= timer_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      winner_q      <= winner_d;
      game_active_q <= (state_d == StFight);
      round_rst_q   <= (state_d == StIdle) || (state_d == StReset);
    end
  end

  assign game_active = game_active_q;
  assign round_rst   = round_rst_q;
  assign p1_rounds   = p1_q;
  assign p2_rounds   = p2_q;
  assign round_timer = timer_q;
  assign phase       = state_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller with small timing parameters.
// Expected output snapshots are queued as stimulus is applied and popped when
// the DUT reaches the corresponding point.
module tb_round_controller;

  logic       clk, rst, frame_tick, start;
  logic [2:0] player1_health, player2_health;
  logic       game_active, round_rst;
  logic [1:0] p1_rounds, p2_rounds;
  logic [6:0] round_timer;
  logic [2:0] phase;
  logic [1:0] winner;

  round_controller #(
    .ROUNDS_TO_WIN   (2),
    .ROUND_SECONDS   (5),
    .FRAMES_PER_SEC  (2),
    .COUNTDOWN_FRAMES(3),
    .KO_HOLD_FRAMES  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start         (start),
    .player1_health(player1_health),
    .player2_health(player2_health),
    .game_active   (game_active),
    .round_rst     (round_rst),
    .p1_rounds     (p1_rounds),
    .p2_rounds     (p2_rounds),
    .round_timer   (round_timer),
    .phase         (phase),
    .winner        (winner)
  );

  typedef struct packed {
    logic [2:0] ph;
    logic       ga;
    logic       rr;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [6:0] tm;
    logic [1:0] wn;
  } snap_t;

  snap_t exp_q[$];
  int    exp_n_q[$];
  int    passed = 0;
  int    total = 0;
  int    cd_ticks = 0;
  int    fight_ticks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every 4 clocks, changed on negedge so it is stable at posedge.
  initial begin
    frame_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  end

  // Count ticks consumed in COUNTDOWN and FIGHT; cleared whenever a round restarts.
  always @(posedge clk) begin
    if (phase == 3'd1 || phase == 3'd0) begin
      cd_ticks    <= 0;
      fight_ticks <= 0;
    end else if (frame_tick) begin
      if (phase == 3'd2) cd_ticks <= cd_ticks + 1;
      if (phase == 3'd3) fight_ticks <= fight_ticks + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic snap_t mk(input int ph, input int ga, input int rr, input int p1,
                               input int p2, input int tm, input int wn);
    snap_t s;
    s.ph = 3'(ph);
    s.ga = 1'(ga);
    s.rr = 1'(rr);
    s.p1 = 2'(p1);
    s.p2 = 2'(p2);
    s.tm = 7'(tm);
    s.wn = 2'(wn);
    return s;
  endfunction

  function automatic snap_t cur();
    return {phase, game_active, round_rst, p1_rounds, p2_rounds, round_timer, winner};
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("phase=%0d ga=%0d rr=%0d p1=%0d p2=%0d timer=%0d winner=%0d",
                     s.ph, s.ga, s.rr, s.p1, s.p2, s.tm, s.wn);
  endfunction

  // Timeouts count as failed checks so a stuck DUT still reaches the summary.
  task automatic wait_phase(input logic [2:0] p, input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (phase !== p && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (phase !== p) begin
      total++;
      $display("FAIL %s: timeout, phase=%0d required %0d", name, phase, p);
    end
  endtask

  task automatic test_reset();
    snap_t e;
    rst = 1'b1;
    start = 1'b0;
    player1_health = 3'd3;
    player2_health = 3'd3;
    exp_q.push_back(mk(0, 0, 1, 0, 0, 5, 0));
    repeat (2) @(negedge clk);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL reset_state: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_start_countdown();
    snap_t e;
    int n;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 0, 0, 5, 0));
    @(negedge clk);
    start = 1'b0;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL enter_reset: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    exp_q.push_back(mk(2, 0, 0, 0, 0, 5, 0));
    @(negedge clk);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL enter_countdown: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    exp_q.push_back(mk(3, 1, 0, 0, 0, 5, 0));
    exp_n_q.push_back(3);
    wait_phase(3'd3, 40, "fight_entry");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL fight_entry: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    n = exp_n_q.pop_front(); total++;
    if (cd_ticks !== n) $display("FAIL countdown_ticks: got %0d want %0d", cd_ticks, n);
    else passed++;
  endtask

  task automatic test_ko_p1();
    snap_t e;
    player1_health = 3'd0;
    exp_q.push_back(mk(4, 0, 0, 0, 1, 5, 0));
    @(negedge clk);
    player1_health = 3'd3;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL p1_ko: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    exp_q.push_back(mk(1, 0, 1, 0, 1, 5, 0));
    wait_phase(3'd1, 20, "ko_hold");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL ko_hold_to_reset: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
  endtask

  task automatic test_wrap_ko();
    snap_t e;
    exp_q.push_back(mk(3, 1, 0, 0, 1, 5, 0));
    wait_phase(3'd3, 40, "round2_fight");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL round2_fight: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    player1_health = 3'd7;
    exp_q.push_back(mk(4, 0, 0, 0, 2, 5, 0));
    @(negedge clk);
    player1_health = 3'd3;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL wrap_ko: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    exp_q.push_back(mk(5, 0, 0, 0, 2, 5, 2));
    wait_phase(3'd5, 20, "match_over_p2");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL match_over_p2: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    start = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 0, 0, 5, 0));
    @(negedge clk);
    start = 1'b0;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL restart_clears: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
  endtask

  task automatic test_timeout();
    snap_t e;
    int n;
    exp_q.push_back(mk(3, 1, 0, 0, 0, 5, 0));
    wait_phase(3'd3, 40, "timeout_fight");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL timeout_fight: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    player1_health = 3'd2;
    player2_health = 3'd1;
    exp_q.push_back(mk(4, 0, 0, 1, 0, 0, 0));
    exp_n_q.push_back(10);
    wait_phase(3'd4, 60, "timeout_p1");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL timeout_p1_wins: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    n = exp_n_q.pop_front(); total++;
    if (fight_ticks !== n) $display("FAIL fight_ticks: got %0d want %0d", fight_ticks, n);
    else passed++;
    player1_health = 3'd2;
    player2_health = 3'd2;
    exp_q.push_back(mk(3, 1, 0, 1, 0, 5, 0));
    wait_phase(3'd3, 60, "timer_reload");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL timer_reload: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    exp_q.push_back(mk(4, 0, 0, 2, 1, 0, 0));
    wait_phase(3'd4, 60, "timeout_draw");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL timeout_draw: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    exp_q.push_back(mk(5, 0, 0, 2, 1, 0, 1));
    wait_phase(3'd5, 20, "match_over_p1");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL match_over_p1: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    player1_health = 3'd3;
    player2_health = 3'd3;
  endtask

  task automatic test_double_ko();
    snap_t e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(mk(2, 0, 0, 0, 0, 5, 0));
    @(negedge clk);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL restart_countdown: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    for (int r = 0; r < 3; r++) begin
      wait_phase(3'd3, 60, "double_ko_fight");
      player1_health = (r == 1) ? 3'd3 : 3'd0;
      player2_health = (r == 0) ? 3'd3 : 3'd0;
      exp_q.push_back(mk(4, 0, 0, (r == 0) ? 0 : r, (r == 2) ? 2 : 1, 5, 0));
      @(negedge clk);
      player1_health = 3'd3;
      player2_health = 3'd3;
      e = exp_q.pop_front(); total++;
      if (cur() !== e) $display("FAIL ko_round%0d: got %s want %s", r, fmt(cur()), fmt(e));
      else passed++;
    end
    exp_q.push_back(mk(5, 0, 0, 2, 2, 5, 3));
    wait_phase(3'd5, 20, "match_over_draw");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL match_over_draw: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
  endtask

  task automatic test_rst_mid_fight();
    snap_t e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_phase(3'd3, 60, "setup_fight");
    player2_health = 3'd0;
    exp_q.push_back(mk(4, 0, 0, 1, 0, 5, 0));
    @(negedge clk);
    player2_health = 3'd3;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL setup_p1_point: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    exp_q.push_back(mk(3, 1, 0, 1, 0, 5, 0));
    wait_phase(3'd3, 60, "fight_before_rst");
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL fight_before_rst: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    rst = 1'b1;
    exp_q.push_back(mk(0, 0, 1, 0, 0, 5, 0));
    @(negedge clk);
    rst = 1'b0;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL mid_fight_rst: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
  endtask

  task automatic test_start_ignored();
    snap_t e;
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    // COUNTDOWN needs 3 ticks (>= 9 clocks), so 4 clocks of start stay inside it.
    start = 1'b1;
    exp_q.push_back(mk(2, 0, 0, 0, 0, 5, 0));
    repeat (4) @(negedge clk);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) $display("FAIL start_ignored_countdown: got %s want %s", fmt(cur()), fmt(e));
    else passed++;
    start = 1'b0;
    exp_n_q.push_back(3);
    wait_phase(3'd3, 40, "fight_after_rst");
    n = exp_n_q.pop_front(); total++;
    if (cd_ticks !== n) $display("FAIL countdown_ticks_after_rst: got %0d want %0d", cd_ticks, n);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_start_countdown();
    test_ko_p1();
    test_wrap_ko();
    test_timeout();
    test_double_ko();
    test_rst_mid_fight();
    test_start_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Consumes the per-player health values from the health tracking stage and sequences a best-of-N match: countdown, fight, KO/timeout, round end and match over.
- Drives `round_rst` back into the health stage and player logic, and `game_active` to gate player input.
- Exposes round scores, the round timer and the winner to the display/HUD logic.

Parameters:
- ROUNDS_TO_WIN, 2: round wins required to take the match (1..3).
- ROUND_SECONDS, 60: round timer start value in seconds (max 127).
- FRAMES_PER_SEC, 60: frame_tick pulses per timer second.
- COUNTDOWN_FRAMES, 180: frame ticks spent in countdown before the fight.
- KO_HOLD_FRAMES, 120: frame ticks held in round-end before the next round or match over.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-clk pulse per video frame
- start  in  1  start/continue request, level or pulse, sampled each clk
- player1_health  in  3  P1 health, 3 = full
- player2_health  in  3  P2 health
- game_active  out  1  high only in FIGHT; players may move/attack
- round_rst  out  1  resets health stage and player positions
- p1_rounds  out  2  P1 rounds won
- p2_rounds  out  2  P2 rounds won
- round_timer  out  7  seconds remaining
- phase  out  3  FSM state code
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- All outputs are registered. On rst:
  - phase=IDLE, round_rst=1, game_active=0.
  - Scores are 0, round_timer=ROUND_SECONDS, winner=00.
  - Internal frame and second counters are 0.
- KO detect: a health value of 0 or >=4 is dead. The >=4 case covers a wrapped down-count. Detection is combinational on the inputs and acted on at the next clk edge.
- Counters advance only on clk edges where frame_tick=1. frame_tick is ignored outside COUNTDOWN/FIGHT/ROUND_END.
- States (phase code):
  - IDLE (0): round_rst=1. If start=1 → RESET and clear scores/winner.
  - RESET (1): exactly one clk. round_rst=1, round_timer←ROUND_SECONDS, frame counter←0. Then → COUNTDOWN.
  - COUNTDOWN (2): round_rst=0. After COUNTDOWN_FRAMES ticks → FIGHT; the transition happens on the edge that samples the last tick.
  - FIGHT (3): game_active=1.
    - A seconds sub-counter counts FRAMES_PER_SEC ticks, then round_timer decrements by 1. round_timer saturates at 0.
    - If any player is dead, or round_timer==0 → ROUND_END, with game_active=0 from that edge.
  - ROUND_END (4): on entry award points:
    - Exactly one player dead: the other player scores +1.
    - Both dead (double KO): both score +1.
    - Timeout with none dead: the higher health scores. Equal health: both score.
    - KO takes priority over timeout on the same edge.
    - After KO_HOLD_FRAMES ticks: if either score == ROUNDS_TO_WIN → MATCH_OVER, else → RESET.
  - MATCH_OVER (5): winner set on entry:
    - 01 if only P1 reached the target.
    - 10 if only P2 reached the target.
    - 11 if both reached it.
    - Scores hold. If start=1 → RESET, clearing scores and winner.
- Scores saturate at 3; the increment uses the registered value, never wraps.
- start is ignored in RESET/COUNTDOWN/FIGHT/ROUND_END.
- rst asserted mid-operation: returns to IDLE on the same edge with the full reset values. It overrides any pending transition.
- Unused phase codes 6/7 → IDLE.

Test Plan:
Parameters for all scenarios: ROUNDS_TO_WIN=2, ROUND_SECONDS=5, FRAMES_PER_SEC=2, COUNTDOWN_FRAMES=3, KO_HOLD_FRAMES=2, frame_tick every 4 clk.
1. rst, then start pulse → phase 0→1 (round_rst high for 1 clk) → 2; FIGHT with game_active=1 after the 3rd tick; round_timer=5.
2. In FIGHT, hold P2 health at 3 and drop P1 health to 0 → next edge phase=4, game_active=0, p2_rounds=1; after 2 ticks phase=1.
3. Second round, P1 health goes 3→7 (wrap) → treated as dead, p2_rounds=2; after hold phase=5, winner=10; start → scores 0, phase=1.
4. FIGHT with healths held at 2 and 1 → round_timer 5→0 over 10 ticks, then phase=4, p1_rounds+1. Equal healths 2/2 → both +1.
5. Both healths go 0 on the same clk at 1-1 → both scores 2, phase=5, winner=11.
6. rst asserted mid-FIGHT with scores 1/0 → next edge phase=0, scores 0, round_rst=1, game_active=0; start while in COUNTDOWN has no effect.
